// File: rtl/int_to_float_pipe_if.sv
// Sample-in / float-out handshake bundle for the int-to-float converter.
// The master side is the environment, the slave side is the converter.
interface int_to_float_pipe_if #(
  parameter int DATA_WIDTH = 24,
  parameter int CH_W       = 1
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] data_in;
  logic [CH_W-1:0]       in_chan;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           float_out;
  logic [CH_W-1:0]       out_chan;

  modport master (
    output in_valid, data_in, in_chan, out_ready,
    input  in_ready, out_valid, float_out, out_chan
  );

  modport slave (
    input  in_valid, data_in, in_chan, out_ready,
    output in_ready, out_valid, float_out, out_chan
  );
endinterface

// File: rtl/int_to_float_pipe.sv
// Integer -> IEEE-754 single converter, 3 register stages, 1 sample/clk.
// Global stall when the output register is full and not taken; in_ready = ~stall.
module int_to_float_pipe #(
  parameter int DATA_WIDTH = 24,
  parameter int CHANNELS   = 2,
  parameter int IS_SIGNED  = 1,
  parameter int NORMALIZE  = 0
) (
  input  logic            clk,
  input  logic            rst,
  int_to_float_pipe_if.slave bus
);
  localparam int W    = DATA_WIDTH;
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int OFFS = (NORMALIZE != 0) ? ((IS_SIGNED != 0) ? W - 1 : W) : 0;

  typedef struct packed {
    logic            vld;
    logic            sign;
    logic [W-1:0]    mag;
    logic [CH_W-1:0] chan;
  } s1_t;

  typedef struct packed {
    logic            vld;
    logic            sign;
    logic            zero;
    logic [5:0]      pos;
    logic [W-2:0]    frac;
    logic [CH_W-1:0] chan;
  } s2_t;

  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic            stall, en;
  logic            out_vld;
  logic [31:0]     out_flt;
  logic [CH_W-1:0] out_ch;
  logic [5:0]      pos;
  logic [W-1:0]    shifted;
  logic [55:0]     ext;
  logic            guard, sticky;
  logic [23:0]     rnd;
  logic [7:0]      exp_w;
  logic [31:0]     result;

  assign stall         = out_vld & ~bus.out_ready;
  assign en            = ~stall;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = out_vld;
  assign bus.float_out = out_flt;
  assign bus.out_chan  = out_ch;

  // S1: sign and magnitude; unary minus in W bits maps -2^(W-1) to 2^(W-1)
  always_comb begin
    s1_d.vld  = bus.in_valid;
    s1_d.sign = (IS_SIGNED != 0) & bus.data_in[W-1];
    s1_d.mag  = s1_d.sign ? -bus.data_in : bus.data_in;
    s1_d.chan = bus.in_chan;
  end

  // S2: leading-one position and normalising left shift
  always_comb begin
    pos = '0;
    for (int i = 0; i < W; i++) begin
      if (s1_q.mag[i]) pos = 6'(i);
    end
    shifted   = s1_q.mag << (6'(W - 1) - pos);
    s2_d.vld  = s1_q.vld;
    s2_d.sign = s1_q.sign;
    s2_d.zero = ~shifted[W-1];
    s2_d.pos  = pos;
    s2_d.frac = shifted[W-2:0];
    s2_d.chan = s1_q.chan;
  end

  // S3: bits below the leading one are left-aligned into a 56-bit window so
  // that [55:33] is the fraction, [32] the guard and [31:0] the sticky field.
  always_comb begin
    ext    = 56'(s2_q.frac) << (57 - W);
    guard  = ext[32];
    sticky = |ext[31:0];
    rnd    = {1'b0, ext[55:33]} + 24'(guard & (sticky | ext[33]));
    exp_w  = 8'd127 + 8'(s2_q.pos) + 8'(rnd[23]) - 8'(OFFS);
    result = s2_q.zero ? 32'h0 : {s2_q.sign, exp_w, rnd[22:0]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      out_vld <= 1'b0;
      out_flt <= '0;
      out_ch  <= '0;
    end else if (en) begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      out_vld <= s2_q.vld;
      out_flt <= result;
      out_ch  <= s2_q.chan;
    end
  end
endmodule

// File: tb/tb_int_to_float_pipe.sv
// Directed + randomized bench for int_to_float_pipe over four parameter sets.
module tb_int_to_float_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int_to_float_pipe_if #(.DATA_WIDTH(24), .CH_W(1)) a ();
  int_to_float_pipe_if #(.DATA_WIDTH(24), .CH_W(1)) n ();
  int_to_float_pipe_if #(.DATA_WIDTH(32), .CH_W(1)) w ();
  int_to_float_pipe_if #(.DATA_WIDTH(16), .CH_W(1)) u ();

  int_to_float_pipe #(.DATA_WIDTH(24), .CHANNELS(2), .IS_SIGNED(1), .NORMALIZE(0))
    u_def (.clk(clk), .rst(rst), .bus(a.slave));
  int_to_float_pipe #(.DATA_WIDTH(24), .CHANNELS(2), .IS_SIGNED(1), .NORMALIZE(1))
    u_nrm (.clk(clk), .rst(rst), .bus(n.slave));
  int_to_float_pipe #(.DATA_WIDTH(32), .CHANNELS(2), .IS_SIGNED(1), .NORMALIZE(0))
    u_w32 (.clk(clk), .rst(rst), .bus(w.slave));
  int_to_float_pipe #(.DATA_WIDTH(16), .CHANNELS(2), .IS_SIGNED(0), .NORMALIZE(0))
    u_u16 (.clk(clk), .rst(rst), .bus(u.slave));

  int n_assert = 0;
  int n_fail   = 0;

  logic [23:0] def_in  [5] = '{24'h000001, 24'hFFFFFF, 24'h7FFFFF, 24'h800000, 24'h000000};
  logic [31:0] def_exp [5] = '{32'h3F800000, 32'hBF800000, 32'h4AFFFFFE, 32'hCB000000, 32'h00000000};
  logic [23:0] nrm_in  [3] = '{24'h400000, 24'h800000, 24'hC00000};
  logic [31:0] nrm_exp [3] = '{32'h3F000000, 32'hBF800000, 32'hBF000000};
  logic [31:0] w32_in  [3] = '{32'h7FFFFFFF, 32'h01000001, 32'h01000003};
  logic [31:0] w32_exp [3] = '{32'h4F000000, 32'h4B800000, 32'h4B800002};
  logic [15:0] u16_in  [2] = '{16'hFFFF, 16'h8000};
  logic [31:0] u16_exp [2] = '{32'h477FFF00, 32'h47000000};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer value, binary exponent by search, mantissa rounded
  // to nearest-even with plain integer arithmetic.
  function automatic logic [31:0] ref_f(input longint unsigned raw, input int wd,
                                        input bit sgn, input bit nrm);
    longint unsigned m, q, rem, half;
    bit s;
    int e, sh, offs;
    s = sgn && raw[wd-1];
    m = s ? ((64'd1 << wd) - raw) : raw;
    if (m == 0) return 32'h0;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      sh   = e - 23;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    offs = nrm ? (sgn ? wd - 1 : wd) : 0;
    return {s, 8'(127 + e - offs), 23'(q - (64'd1 << 23))};
  endfunction

  logic [32:0] exp_q [$];
  logic [32:0] qw [$];
  logic [32:0] qn [$];
  logic [32:0] qu [$];
  logic [32:0] e33;
  logic        prev_stall;
  logic [31:0] prev_f;
  logic        prev_c;
  int          sent, got;
  bit          v;

  initial begin
    a.in_valid = 0; a.data_in = '0; a.in_chan = '0; a.out_ready = 1;
    n.in_valid = 0; n.data_in = '0; n.in_chan = '0; n.out_ready = 1;
    w.in_valid = 0; w.data_in = '0; w.in_chan = '0; w.out_ready = 1;
    u.in_valid = 0; u.data_in = '0; u.in_chan = '0; u.out_ready = 1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(a.out_valid), 64'd0);
    check("rst_float_out", 64'(a.float_out), 64'd0);
    check("rst_out_chan", 64'(a.out_chan), 64'd0);
    rst = 1'b1;
    #1;
    check("rst_in_ready", 64'(a.in_ready), 64'd1);

    // Directed vectors on all four configurations, exact 3-cycle latency
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k >= 3 && k < 8) check("def_out", {a.out_valid, a.out_chan, a.float_out}, {1'b1, 1'((k - 3) % 2), def_exp[k-3]});
      else check("def_idle", 64'(a.out_valid), 64'd0);
      if (k >= 3 && k < 6) check("nrm_out", {n.out_valid, n.float_out}, {1'b1, nrm_exp[k-3]});
      else check("nrm_idle", 64'(n.out_valid), 64'd0);
      if (k >= 3 && k < 6) check("w32_out", {w.out_valid, w.float_out}, {1'b1, w32_exp[k-3]});
      else check("w32_idle", 64'(w.out_valid), 64'd0);
      if (k >= 3 && k < 5) check("u16_out", {u.out_valid, u.float_out}, {1'b1, u16_exp[k-3]});
      else check("u16_idle", 64'(u.out_valid), 64'd0);
      a.in_valid = (k < 5); if (k < 5) begin a.data_in = def_in[k]; a.in_chan = 1'(k % 2); end
      n.in_valid = (k < 3); if (k < 3) n.data_in = nrm_in[k];
      w.in_valid = (k < 3); if (k < 3) w.data_in = w32_in[k];
      u.in_valid = (k < 2); if (k < 2) u.data_in = u16_in[k];
    end

    // Backpressure: ramp then random data, random out_ready, ordered + stable
    prev_stall = 1'b0; prev_f = '0; prev_c = 1'b0; sent = 0; got = 0;
    for (int cyc = 0; cyc < 8000 && got < 1300; cyc++) begin
      @(negedge clk);
      if (prev_stall)
        check("stall_hold", {a.out_valid, a.out_chan, a.float_out}, {1'b1, prev_c, prev_f});
      a.out_ready = 1'($urandom_range(0, 1));
      if (sent < 1300) begin
        a.in_valid = 1'b1;
        a.data_in  = (sent < 1000) ? 24'(sent) : 24'($urandom);
        a.in_chan  = 1'(sent % 2);
      end else begin
        a.in_valid = 1'b0;
      end
      #1;
      check("in_ready_rule", 64'(a.in_ready), 64'(!(a.out_valid && !a.out_ready)));
      if (a.out_valid && a.out_ready) begin
        check("out_has_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e33 = exp_q.pop_front();
          check("bp_out", {a.out_chan, a.float_out}, e33);
        end
        got++;
      end
      if (a.in_valid && a.in_ready) begin
        exp_q.push_back({a.in_chan, ref_f(64'(a.data_in), 24, 1'b1, 1'b0)});
        sent++;
      end
      prev_stall = a.out_valid && !a.out_ready;
      prev_f     = a.float_out;
      prev_c     = a.out_chan;
    end
    check("bp_out_count", 64'(got), 64'd1300);
    @(negedge clk);
    a.in_valid = 1'b0; a.out_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Random data with bubbles on the other configurations, out_ready held high
    for (int k = 0; k < 206; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        e33 = qw.pop_front();
        if (e33[32]) check("w32_rand", {w.out_valid, w.float_out}, e33);
        else check("w32_bubble", 64'(w.out_valid), 64'd0);
        e33 = qn.pop_front();
        if (e33[32]) check("nrm_rand", {n.out_valid, n.float_out}, e33);
        else check("nrm_bubble", 64'(n.out_valid), 64'd0);
        e33 = qu.pop_front();
        if (e33[32]) check("u16_rand", {u.out_valid, u.float_out}, e33);
        else check("u16_bubble", 64'(u.out_valid), 64'd0);
      end
      v = (k < 200) && ($urandom_range(0, 3) != 0);
      w.in_valid = v; w.data_in = 32'($urandom);
      qw.push_back(v ? {1'b1, ref_f(64'(w.data_in), 32, 1'b1, 1'b0)} : 33'h0);
      v = (k < 200) && ($urandom_range(0, 3) != 0);
      n.in_valid = v; n.data_in = 24'($urandom);
      qn.push_back(v ? {1'b1, ref_f(64'(n.data_in), 24, 1'b1, 1'b1)} : 33'h0);
      v = (k < 200) && ($urandom_range(0, 3) != 0);
      u.in_valid = v; u.data_in = 16'($urandom);
      qu.push_back(v ? {1'b1, ref_f(64'(u.data_in), 16, 1'b0, 1'b0)} : 33'h0);
    end
    w.in_valid = 1'b0; n.in_valid = 1'b0; u.in_valid = 1'b0;

    // Reset with three samples in flight (output stalled so all stages are full)
    a.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a.in_valid = 1'b1; a.data_in = 24'(k + 5); a.in_chan = 1'(k % 2);
    end
    @(negedge clk);
    a.in_valid = 1'b0;
    check("full_before_rst", 64'(a.out_valid), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_valid", 64'(a.out_valid), 64'd0);
    check("async_rst_float", 64'(a.float_out), 64'd0);
    @(negedge clk);
    rst = 1'b1; a.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_quiet", 64'(a.out_valid), 64'd0);
    end
    a.in_valid = 1'b1; a.data_in = 24'h000002; a.in_chan = 1'b1;
    @(negedge clk);
    a.in_valid = 1'b0;
    check("post_rst_lat1", 64'(a.out_valid), 64'd0);
    @(negedge clk);
    check("post_rst_lat2", 64'(a.out_valid), 64'd0);
    @(negedge clk);
    check("post_rst_out", {a.out_valid, a.out_chan, a.float_out}, {1'b1, 1'b1, 32'h40000000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
